mem_responder: RTL and testbench

Multi-cycle data-memory responder for the MEM stage of the pipelined MIPS core. It accepts one load/store request at a time over a valid/ready handshake and performs word, halfword or byte accesses on a little-endian word array. Loads are sign- or zero-extended; misaligned and out-of-range accesses are flagged. It sits behind the MEM stage: the stage drives requests, and the hazard unit stalls on `busy` until `rsp_valid` arrives.

---
 rtl/mem_responder.sv | 164 ++++++++++++++++
 tb/tb_mem_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: multi-cycle load/store responder over a little-endian word
// array, with sign/zero-extended narrow loads and error flagging.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_width,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  width;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    state_t         state_q, state_d;
    req_t           req_q, req_d, req_in, rq;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [31:0]    rsp_rdata_q, rsp_rdata_d;
    logic           rsp_err_q, rsp_err_d;
    logic [31:0]    mem_q [DEPTH_WORDS];

    logic           accept, enter_resp, err, wr_en;
    logic [AW-1:0]  idx;
    logic [1:0]     lane;
    logic [31:0]    rd_word, ld_data, wr_pat, wr_mask, wr_word;
    logic [7:0]     byte_v;
    logic [15:0]    half_v;
    logic [3:0]     be;

    assign req_ready = (state_q != S_WAIT);
    assign busy      = (state_q == S_WAIT);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Next-state, capture and counter; WAIT is left on the edge the counter reaches zero
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        accept     = req_valid && req_ready;
        req_in     = '{we: req_we, width: req_width, sign: req_sign,
                       addr: req_addr, wdata: req_wdata};
        case (state_q)
            S_IDLE, S_RESP: begin
                if (accept) begin
                    req_d = req_in;
                    if (LATENCY == 1) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                        cnt_d      = '0;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CW'(LATENCY - 1);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Access decode: error check, load extraction and store lane merge
    always_comb begin
        // With single-cycle latency the response is formed from the request being accepted
        rq      = (LATENCY == 1) ? req_in : req_q;
        lane    = rq.addr[1:0];
        idx     = rq.addr[AW+1:2];
        err     = (rq.width == 2'b11)
               || (rq.width == 2'b00 && rq.addr[1:0] != 2'b00)
               || (rq.width == 2'b01 && rq.addr[0])
               || ({2'b00, rq.addr[31:2]} >= 32'(DEPTH_WORDS));
        rd_word = mem_q[idx];
        byte_v  = 8'(rd_word >> {lane, 3'b000});
        half_v  = rq.addr[1] ? rd_word[31:16] : rd_word[15:0];
        ld_data = '0;
        be      = 4'b0000;
        wr_pat  = rq.wdata;
        case (rq.width)
            2'b00: begin
                ld_data = rd_word;
                be      = 4'b1111;
            end
            2'b01: begin
                ld_data = {{16{rq.sign & half_v[15]}}, half_v};
                be      = rq.addr[1] ? 4'b1100 : 4'b0011;
                wr_pat  = {2{rq.wdata[15:0]}};
            end
            2'b10: begin
                ld_data = {{24{rq.sign & byte_v[7]}}, byte_v};
                be      = 4'b0001 << lane;
                wr_pat  = {4{rq.wdata[7:0]}};
            end
            default: ;
        endcase
        wr_mask     = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        wr_word     = (rd_word & ~wr_mask) | (wr_pat & wr_mask);
        wr_en       = enter_resp && rq.we && !err;
        rsp_valid_d = enter_resp;
        rsp_err_d   = enter_resp && err;
        rsp_rdata_d = (enter_resp && !rq.we && !err) ? ld_data : 32'h0;
    end

    // Control and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            req_q       <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Word array; reset clears contents, stores commit on the edge entering RESP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[idx] <= wr_word;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder (DEPTH_WORDS=1024, LATENCY=2).
module tb_mem_responder;

    localparam int unsigned DEPTH   = 1024;
    localparam int unsigned LAT     = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_sign;
    logic [1:0]  req_width;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   busy_cnt = 0;
    logic seen_in_resp;

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_width (req_width),
        .req_sign  (req_sign),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Response monitor: pops the scoreboard and checks data, error, latency and busy time
    always @(negedge clk) begin
        if (reset) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_rsp_valid", 32'(rsp_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check({e.tag, "_rdata"}, rsp_rdata, e.rdata);
                    check({e.tag, "_err"}, 32'(rsp_err), 32'(e.err));
                    check({e.tag, "_latency"}, 32'(cyc - e.cyc), 32'(LAT));
                    check({e.tag, "_busy_cycles"}, 32'(busy_cnt), 32'(LAT - 1));
                end
                busy_cnt = 0;
            end
        end
    end

    // Present a request and push its expected response once it is accepted
    task automatic issue(input string tag, input logic we, input logic [1:0] w,
                         input logic s, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_d, input logic exp_e, input bit hold);
        exp_t e;
        int   waitc;
        waitc = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_width = w;
        req_sign  = s;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!req_ready) begin
            check({tag, "_accept_timeout"}, 32'(req_ready), 32'd1);
        end else begin
            seen_in_resp = rsp_valid;
            e.tag   = tag;
            e.rdata = exp_d;
            e.err   = exp_e;
            e.cyc   = cyc;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("response_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    endtask

    // Stimulus: each request followed by its expected response
    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_width = 2'b00;
        req_sign  = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        issue("st_w_10",  1, 2'b00, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0); wait_rsp();
        issue("ld_w_10",  0, 2'b00, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0); wait_rsp();
        issue("ld_bs_13", 0, 2'b10, 1, 32'h13, 32'h0, 32'hFFFFFFDE, 0, 0); wait_rsp();
        issue("ld_bu_13", 0, 2'b10, 0, 32'h13, 32'h0, 32'h000000DE, 0, 0); wait_rsp();
        issue("ld_hs_10", 0, 2'b01, 1, 32'h10, 32'h0, 32'hFFFFBEEF, 0, 0); wait_rsp();

        issue("st_b_11",  1, 2'b10, 0, 32'h11, 32'h12345677, 32'h0, 0, 0); wait_rsp();
        issue("ld_w_10b", 0, 2'b00, 0, 32'h10, 32'h0, 32'hDEAD77EF, 0, 0); wait_rsp();
        issue("st_h_12",  1, 2'b01, 0, 32'h12, 32'hAAAA5555, 32'h0, 0, 0); wait_rsp();
        issue("ld_w_10c", 0, 2'b00, 0, 32'h10, 32'h0, 32'h555577EF, 0, 0); wait_rsp();

        issue("ld_w_mis", 0, 2'b00, 0, 32'h12, 32'h0, 32'h0, 1, 0); wait_rsp();
        issue("st_h_mis", 1, 2'b01, 0, 32'h13, 32'hFFFFFFFF, 32'h0, 1, 0); wait_rsp();
        issue("ld_w11",   0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1, 0); wait_rsp();
        issue("st_w11",   1, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1, 0); wait_rsp();
        issue("st_oor",   1, 2'b00, 0, 32'(4 * DEPTH), 32'hCAFEF00D, 32'h0, 1, 0); wait_rsp();
        issue("ld_w_10d", 0, 2'b00, 0, 32'h10, 32'h0, 32'h555577EF, 0, 0); wait_rsp();
        issue("ld_w_00",  0, 2'b00, 0, 32'h00, 32'h0, 32'h0, 0, 0); wait_rsp();

        issue("b2b_st",   1, 2'b00, 0, 32'h40, 32'h13579BDF, 32'h0, 0, 1);
        issue("b2b_ld",   0, 2'b00, 0, 32'h40, 32'h0, 32'h13579BDF, 0, 0);
        check("b2b_accept_in_resp", 32'(seen_in_resp), 32'd1);
        wait_rsp();
        issue("ld_hu_42", 0, 2'b01, 0, 32'h42, 32'h0, 32'h00001357, 0, 0); wait_rsp();
        issue("ld_bs_41", 0, 2'b10, 1, 32'h41, 32'h0, 32'hFFFFFF9B, 0, 0); wait_rsp();

        // Reset during WAIT of a store: no response, outputs clear, store dropped
        issue("st_abort", 1, 2'b00, 0, 32'h20, 32'h11111111, 32'h0, 0, 0);
        check("abort_busy_before_reset", 32'(busy), 32'd1);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check_reset_outputs("abort");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_no_late_rsp", 32'(rsp_valid), 32'd0);
        issue("ld_w_20",  0, 2'b00, 0, 32'h20, 32'h0, 32'h0, 0, 0); wait_rsp();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule
